// File: rtl/rvm_ifetch.sv
// rtl/rvm_ifetch.sv - instruction fetch unit with req/gnt/rvalid memory port
module rvm_ifetch #(
    parameter int unsigned TIMEOUT     = 16,
    parameter logic [31:0] RESET_INSTR = 32'h00000013
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        fetch_en,
    input  logic [31:0] pc,
    input  logic        flush,
    input  logic        instr_ack,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [1:0]  fault,
    output logic        busy,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    input  logic        mem_err
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_DONE  = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    localparam logic [1:0] F_NONE  = 2'b00;
    localparam logic [1:0] F_ALIGN = 2'b01;
    localparam logic [1:0] F_BUS   = 2'b10;
    localparam logic [1:0] F_TMO   = 2'b11;

    // Counter only needs to reach TIMEOUT-1; a zero TIMEOUT never compares.
    localparam int unsigned   CW       = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);

    state_t        state_q, state_d;
    logic [31:0]   instr_q, instr_d;
    logic [31:0]   instr_pc_q, instr_pc_d;
    logic [1:0]    fault_q, fault_d;
    logic [31:0]   mem_addr_q, mem_addr_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            instr_q    <= RESET_INSTR;
            instr_pc_q <= '0;
            fault_q    <= F_NONE;
            mem_addr_q <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            fault_q    <= fault_d;
            mem_addr_q <= mem_addr_d;
            cnt_q      <= cnt_d;
        end
    end

    // Next-state and captured-data logic; flush outranks every other input
    always_comb begin
        state_d    = state_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        fault_d    = fault_q;
        mem_addr_d = mem_addr_q;
        cnt_d      = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (!flush && fetch_en) begin
                    instr_pc_d = pc;
                    if (pc[1:0] != 2'b00) begin
                        fault_d = F_ALIGN;
                        state_d = S_DONE;
                    end else begin
                        mem_addr_d = pc;
                        state_d    = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else if (mem_gnt) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end
            end
            S_WAIT: begin
                if (flush) begin
                    // A response arriving with the flush retires the fetch at once.
                    state_d = mem_rvalid ? S_IDLE : S_DRAIN;
                end else if (mem_rvalid) begin
                    instr_d = mem_rdata;
                    fault_d = mem_err ? F_BUS : F_NONE;
                    state_d = S_DONE;
                end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
                    instr_d = RESET_INSTR;
                    fault_d = F_TMO;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DONE: begin
                if (flush || instr_ack) begin
                    state_d = S_IDLE;
                end
            end
            S_DRAIN: begin
                if (mem_rvalid) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Nothing is held outside DONE, so present the NOP and a clean fault code.
        if (state_d == S_IDLE) begin
            instr_d = RESET_INSTR;
            fault_d = F_NONE;
        end
    end

    // Outputs decoded from the current state and held registers
    always_comb begin
        instr_valid = (state_q == S_DONE);
        busy        = (state_q != S_IDLE);
        mem_req     = (state_q == S_REQ);
        mem_addr    = mem_addr_q;
        instr       = instr_q;
        instr_pc    = instr_pc_q;
        fault       = fault_q;
    end

endmodule

// File: tb/tb_rvm_ifetch.sv
// tb/tb_rvm_ifetch.sv - randomized self-checking bench for rvm_ifetch
module tb_rvm_ifetch;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        resetn, fetch_en, flush, instr_ack;
    logic [31:0] pc;
    logic        instr_valid, busy, mem_req;
    logic [31:0] instr, instr_pc, mem_addr;
    logic [1:0]  fault;
    logic        mem_gnt, mem_rvalid, mem_err;
    logic [31:0] mem_rdata;

    int nerr = 0;
    int nchk = 0;
    int cyc  = 0;

    rvm_ifetch #(.TIMEOUT(16), .RESET_INSTR(NOP)) dut (
        .clk(clk), .resetn(resetn), .fetch_en(fetch_en), .pc(pc), .flush(flush),
        .instr_ack(instr_ack), .instr_valid(instr_valid), .instr(instr),
        .instr_pc(instr_pc), .fault(fault), .busy(busy), .mem_req(mem_req),
        .mem_addr(mem_addr), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Transaction-level model: the result depends only on the request and the response fed in.
    task automatic do_fetch(input logic [31:0] p, input int gd, input int rd,
                            input logic [31:0] d, input logic e, input bit noise);
        int t0, nreq, exp_lat;
        logic mis;
        mis     = (p[1:0] != 2'b00);
        exp_lat = mis ? 1 : gd + rd + 3;
        t0      = cyc;
        nreq    = 0;
        fetch_en = 1'b1; pc = p;
        tick();
        fetch_en = 1'b0; pc = $urandom();
        if (mis) begin
            chk("mis_req", mem_req, 0);
        end else begin
            for (int i = 0; i < gd; i++) begin
                nreq += mem_req;
                if (mem_addr !== p) chk("addr_stable", mem_addr, p);
                if (noise) begin
                    fetch_en = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hBAD0BAD0;
                end
                tick();
                fetch_en = 1'b0; mem_rvalid = 1'b0;
            end
            nreq += mem_req;
            mem_gnt = 1'b1;
            tick();
            mem_gnt = 1'b0;
            chk("req_cycles", nreq, gd + 1);
            for (int i = 0; i < rd; i++) begin
                if (noise) fetch_en = 1'b1;
                tick();
                fetch_en = 1'b0;
            end
            chk("valid_early", instr_valid, 0);
            mem_rvalid = 1'b1; mem_rdata = d; mem_err = e;
            tick();
            mem_rvalid = 1'b0; mem_err = 1'b0;
        end
        chk("latency", cyc - t0, exp_lat);
        chk("valid", instr_valid, 1);
        chk("instr", instr, mis ? NOP : d);
        chk("instr_pc", instr_pc, p);
        chk("fault", fault, mis ? 2'b01 : (e ? 2'b10 : 2'b00));
        instr_ack = 1'b1;
        tick();
        instr_ack = 1'b0;
        chk("ack_valid", instr_valid, 0);
        chk("ack_busy", busy, 0);
    endtask

    initial begin
        int n;
        logic [31:0] rp;
        resetn = 1'b0; fetch_en = 1'b0; flush = 1'b0; instr_ack = 1'b0; pc = '0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; mem_err = 1'b0;
        tick(); tick();
        chk("rst_valid", instr_valid, 0);
        chk("rst_instr", instr, NOP);
        chk("rst_pc", instr_pc, 0);
        chk("rst_fault", fault, 0);
        chk("rst_req", mem_req, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_busy", busy, 0);
        resetn = 1'b1;
        tick();

        do_fetch(32'h100, 0, 0, 32'h00500093, 1'b0, 1'b0);
        do_fetch(32'h200, 3, 5, 32'h12345678, 1'b0, 1'b1);
        do_fetch(32'h102, 0, 0, 32'h0, 1'b0, 1'b0);
        do_fetch(32'h300, 1, 2, 32'hCAFEF00D, 1'b1, 1'b0);

        // Timeout: no response after the grant.
        fetch_en = 1'b1; pc = 32'h400; tick(); fetch_en = 1'b0;
        mem_gnt = 1'b1; tick(); mem_gnt = 1'b0;
        n = 0;
        while (!instr_valid && n < 40) begin tick(); n++; end
        chk("tmo_cycles", n, 16);
        chk("tmo_fault", fault, 2'b11);
        chk("tmo_instr", instr, NOP);
        mem_rvalid = 1'b1; mem_rdata = 32'h55555555; tick(); mem_rvalid = 1'b0;
        chk("tmo_late_instr", instr, NOP);
        chk("tmo_late_fault", fault, 2'b11);
        instr_ack = 1'b1; tick(); instr_ack = 1'b0;
        chk("tmo_idle", busy, 0);

        // Flush in WAIT drains the response, then a clean fetch follows.
        fetch_en = 1'b1; pc = 32'h500; tick(); fetch_en = 1'b0;
        mem_gnt = 1'b1; tick(); mem_gnt = 1'b0;
        flush = 1'b1; tick(); flush = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        chk("drain_busy", busy, 1);
        chk("drain_valid", instr_valid, 0);
        mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF; tick(); mem_rvalid = 1'b0;
        chk("drain_done_busy", busy, 0);
        chk("drain_done_valid", instr_valid, 0);
        do_fetch(32'h504, 0, 1, 32'h00A00113, 1'b0, 1'b0);

        // Flush coinciding with rvalid in WAIT goes straight to IDLE.
        fetch_en = 1'b1; pc = 32'h600; tick(); fetch_en = 1'b0;
        mem_gnt = 1'b1; tick(); mem_gnt = 1'b0;
        flush = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF; tick();
        flush = 1'b0; mem_rvalid = 1'b0;
        chk("flush_rv_busy", busy, 0);
        chk("flush_rv_valid", instr_valid, 0);

        // Flush in DONE, and flush beating fetch_en in IDLE.
        fetch_en = 1'b1; pc = 32'h701; tick(); fetch_en = 1'b0;
        chk("done_valid", instr_valid, 1);
        flush = 1'b1; tick(); flush = 1'b0;
        chk("flush_done_valid", instr_valid, 0);
        flush = 1'b1; fetch_en = 1'b1; pc = 32'h800; tick(); flush = 1'b0; fetch_en = 1'b0;
        chk("flush_fetch_busy", busy, 0);

        // Reset pulse between edges is ignored; reset held over an edge aborts REQ.
        fetch_en = 1'b1; pc = 32'h900; tick(); fetch_en = 1'b0;
        resetn = 1'b0; #2; resetn = 1'b1;
        tick();
        chk("glitch_req", mem_req, 1);
        resetn = 1'b0; tick(); resetn = 1'b1;
        chk("rst_req2", mem_req, 0);
        chk("rst_busy2", busy, 0);
        chk("rst_addr2", mem_addr, 0);
        mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF; tick(); mem_rvalid = 1'b0;
        chk("rst_stale_valid", instr_valid, 0);

        // Randomized fetches against the transaction model.
        for (int k = 0; k < 24; k++) begin
            rp = $urandom();
            rp[1:0] = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            do_fetch(rp, int'($urandom_range(0, 4)), int'($urandom_range(0, 6)),
                     $urandom(), ($urandom_range(0, 3) == 0), bit'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
